if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 SignalPC  input  1  load-use stall request from hazard unit; 1 = hold PC and IF/ID.
REQ-006 Branch  input  1  taken branch/jump resolved in EX; 1 = redirect and flush.
REQ-007 BranchTarget  input  32  redirect address, valid when Branch=1.
REQ-008 ImemData  input  32  instruction read from instruction memory at address PC.
REQ-009 ImemReady  input  1  ImemData valid this cycle.
REQ-010 PC  output  32  current fetch address, registered, drives instruction memory.
REQ-011 IF_ID_PC  output  32  PC of instruction held in IF/ID.
REQ-012 IF_ID_Instruction  output  32  instruction held in IF/ID; feeds decode and hazard unit Instruction input.
REQ-013 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-014 FetchState  output  2  registered state: RUN=2'b00, STALL=2'b01, MEMWAIT=2'b10.
REQ-015 StallCycles  output  16  saturating count of cycles stalled by SignalPC.

Function
REQ-016 Per-edge priority SHALL be: rst > Branch > SignalPC > !ImemReady > normal advance; exactly one action per cycle.
REQ-017 Normal advance (ImemReady=1, no stall/branch): IF_ID_Instruction<=ImemData, IF_ID_PC<=PC, IF_ID_Valid<=1, PC<=PC+4, FetchState<=RUN.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), no flag.
REQ-019 Branch=1: PC<={BranchTarget[31:2],2'b00}, IF_ID_Instruction<=NOP_INSTR, IF_ID_PC<=0, IF_ID_Valid<=0, FetchState<=RUN; overrides SignalPC and ImemReady in same cycle.
REQ-020 SignalPC=1 (Branch=0): PC, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid SHALL hold; FetchState<=STALL; ImemData ignored.
REQ-021 ImemReady=0 (Branch=0, SignalPC=0): PC holds; IF_ID_Instruction<=NOP_INSTR, IF_ID_Valid<=0, IF_ID_PC<=0 (bubble to decode); FetchState<=MEMWAIT.
REQ-022 State transitions: any state -> RUN on normal advance or Branch; any -> STALL on SignalPC; any -> MEMWAIT on !ImemReady; all transitions take effect at the same edge as the action.
REQ-023 StallCycles SHALL increment by 1 each edge where SignalPC=1 and Branch=0, saturating at 16'hFFFF; no other event changes it except reset.
REQ-024 A stall lasting N cycles SHALL delay the IF/ID contents by exactly N cycles with no instruction lost or duplicated.
REQ-025 First instruction after reset SHALL appear in IF/ID one edge after the first cycle with ImemReady=1 and rst=0.
REQ-026 All outputs SHALL be driven directly from registers; no combinational input-to-output path.

Reset
REQ-027 rst=1 at an edge: PC<=RESET_PC, IF_ID_Instruction<=NOP_INSTR, IF_ID_PC<=0, IF_ID_Valid<=0, FetchState<=RUN, StallCycles<=0, regardless of all other inputs.
REQ-028 rst asserted mid-stall or mid-MEMWAIT SHALL abandon that condition entirely; no pending redirect survives reset.

Verification
REQ-029 Reset then ImemReady=1, ImemData=32'h00A00093 -> after 1 edge PC=4, IF_ID_Instruction=32'h00A00093, IF_ID_PC=0, IF_ID_Valid=1, FetchState=RUN.
REQ-030 Steady fetch at PC=8, SignalPC=1 for 2 cycles -> PC stays 8, IF/ID unchanged, FetchState=STALL, StallCycles=2; third cycle SignalPC=0 -> PC=12, IF_ID_PC=8.
REQ-031 SignalPC=1 and Branch=1, BranchTarget=32'h00000103 same cycle -> PC=32'h00000100, IF_ID_Instruction=32'h00000013, IF_ID_Valid=0, StallCycles unchanged.
REQ-032 ImemReady=0 for 3 cycles at PC=16 -> PC=16, IF_ID_Valid=0, IF_ID_Instruction=32'h00000013, FetchState=MEMWAIT; then ImemReady=1 -> IF_ID_PC=16, PC=20.
REQ-033 PC=32'hFFFFFFFC normal advance -> PC=32'h00000000; StallCycles preset to 16'hFFFF plus one stall -> stays 16'hFFFF.
REQ-034 rst=1 during SignalPC=1 stall with PC=32'h40 -> next edge PC=RESET_PC, IF_ID_Valid=0, FetchState=RUN, StallCycles=0.

Source files
------------

// File: rtl/if_id_stage.sv
// IF stage with IF/ID pipeline register: fetch PC, branch redirect/flush,
// load-use stall hold, and bubble insertion while instruction memory is busy.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SignalPC,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] ImemData,
  input  logic        ImemReady,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic [1:0]  FetchState,
  output logic [15:0] StallCycles
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    STALL   = 2'b01,
    MEMWAIT = 2'b10
  } fetch_state_e;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ifid_pc_q, ifid_pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic         ifid_valid_q, ifid_valid_d;
  fetch_state_e state_q, state_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;

  // One action per edge, in priority order: redirect, stall, memory wait, advance.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;

    if (Branch) begin
      pc_d         = {BranchTarget[31:2], 2'b00};
      ifid_pc_d    = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
    end else if (SignalPC) begin
      state_d = STALL;
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else if (!ImemReady) begin
      ifid_pc_d    = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = MEMWAIT;
    end else begin
      pc_d         = pc_q + 32'd4;
      ifid_pc_d    = pc_q;
      ifid_instr_d = ImemData;
      ifid_valid_d = 1'b1;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      state_q      <= RUN;
      stall_cnt_q  <= 16'h0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign PC                = pc_q;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_Valid       = ifid_valid_q;
  assign FetchState        = state_q;
  assign StallCycles       = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a driver pushes model predictions per
// edge, and an independent monitor pops and compares after each edge.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        SignalPC;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic [31:0] ImemData;
  logic        ImemReady;
  logic [31:0] PC;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic [1:0]  FetchState;
  logic [15:0] StallCycles;

  if_id_stage #(.RESET_PC(32'h00000000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .SignalPC(SignalPC), .Branch(Branch),
    .BranchTarget(BranchTarget), .ImemData(ImemData), .ImemReady(ImemReady),
    .PC(PC), .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_Valid(IF_ID_Valid), .FetchState(FetchState), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifPc;
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  state;
    logic [15:0] stalls;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  passes = 0;
  bit  driverDone = 0;

  // Reference state, expressed directly from the behavioural rules.
  logic [31:0] mPc = 32'h0, mIfPc = 32'h0, mInstr = NOP;
  logic        mValid = 1'b0;
  logic [1:0]  mState = 2'b00;
  int          mStalls = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic applyStimulus(input bit r, input bit sp, input bit br,
                               input logic [31:0] bt, input logic [31:0] data, input bit rdy);
    expT e;
    @(negedge clk);
    rst = r; SignalPC = sp; Branch = br; BranchTarget = bt;
    ImemData = data; ImemReady = rdy;
    if (r) begin
      mPc = 32'h0; mIfPc = 32'h0; mInstr = NOP; mValid = 0; mState = 2'b00; mStalls = 0;
    end else if (br) begin
      mPc = bt & 32'hFFFFFFFC; mIfPc = 32'h0; mInstr = NOP; mValid = 0; mState = 2'b00;
    end else if (sp) begin
      mState = 2'b01;
      mStalls = (mStalls >= 65535) ? 65535 : mStalls + 1;
    end else if (!rdy) begin
      mIfPc = 32'h0; mInstr = NOP; mValid = 0; mState = 2'b10;
    end else begin
      mIfPc = mPc; mInstr = data; mValid = 1; mState = 2'b00;
      mPc = 32'((64'(mPc) + 64'd4) % 64'h1_0000_0000);
    end
    e.pc = mPc; e.ifPc = mIfPc; e.instr = mInstr; e.valid = mValid;
    e.state = mState; e.stalls = 16'(mStalls);
    expQ.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh registered result after every edge.
  initial begin : monitor
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check32("PC", PC, e.pc);
        check32("IF_ID_PC", IF_ID_PC, e.ifPc);
        check32("IF_ID_Instruction", IF_ID_Instruction, e.instr);
        check32("IF_ID_Valid", {31'b0, IF_ID_Valid}, {31'b0, e.valid});
        check32("FetchState", {30'b0, FetchState}, {30'b0, e.state});
        check32("StallCycles", {16'b0, StallCycles}, {16'b0, e.stalls});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    @(posedge clk);
    #2;
    check32(name, act, req);
  endtask

  initial begin : driver
    logic [31:0] d;
    rst = 1; SignalPC = 0; Branch = 0; BranchTarget = 0; ImemData = 0; ImemReady = 0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 32'h55, 32'h1234, 1);
    // First fetch, then a two-cycle load-use stall at PC=8.
    applyStimulus(0, 0, 0, 0, 32'h00A00093, 1);
    applyStimulus(0, 0, 0, 0, 32'h00200113, 1);
    applyStimulus(0, 1, 0, 0, 32'hDEADBEEF, 1);
    applyStimulus(0, 1, 0, 0, 32'hCAFEF00D, 0);
    applyStimulus(0, 0, 0, 0, 32'h00300193, 1);
    // Branch beats stall; misaligned target is truncated.
    applyStimulus(0, 1, 1, 32'h00000103, 32'h11111111, 1);
    // Memory wait at PC=16.
    applyStimulus(0, 0, 1, 32'h00000010, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 32'h22222222, 0);
    applyStimulus(0, 0, 0, 0, 32'h00400213, 1);
    // PC wrap at the top of the address space.
    applyStimulus(0, 0, 1, 32'hFFFFFFFE, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h00500293, 1);
    applyStimulus(0, 0, 0, 0, 32'h00600313, 1);
    // Reset in the middle of a stall at PC=0x40.
    applyStimulus(0, 0, 1, 32'h00000040, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 1);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(4) == 0),
                    ($urandom_range(7) == 0), $urandom, d, ($urandom_range(3) != 0));
    end
    // Long stall to reach counter saturation, with branches held off.
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(0, 1, 0, $urandom, $urandom, $urandom_range(1) == 1);
    end
    applyStimulus(0, 0, 0, 0, 32'h00700393, 1);
    checkOutput("StallCycles saturated", {16'b0, StallCycles}, 32'h0000FFFF);
    driverDone = 1;
  end

  initial begin : finisher
    int cycles = 0;
    while (!driverDone && cycles < 90000) begin
      @(posedge clk);
      cycles++;
    end
    if (!driverDone) begin
      checks++;
      $display("[TB] FAIL timeout: driver not done after %0d cycles, expected done", cycles);
    end
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
